// File: rtl/fib_sequence_engine.sv
// rtl/fib_sequence_engine.sv - Fibonacci table sequencer driving a memory port and an external adder
//
// Purpose: on an accepted start, fills memory from BASE_ADDR with F(0)..F(N-1).
//   For each term i it reads F(i-2) and F(i-1), presents them to an external
//   combinational adder, and writes the sum back as F(i). The run ends early
//   with a sticky overflow flag if the unsigned sum wraps.
// Optional feature: macro FIB_SEED_WRITE_EN. When defined, the engine writes
//   the seeds F(0)=0 and F(1)=1 itself. When undefined, those two words must
//   already be in memory and the engine goes straight to the term loop.
// Ports:
//   clockSignal, resetSignal     rising-edge clock, asynchronous active-low reset
//   start, termCount             run request (sampled in IDLE) and term count N
//   busy, done, overflow         run status, one-cycle completion pulse, sticky wrap flag
//   readMemorySignal,
//   writeMemorySignal, address,
//   dataToWrite, dataRead        memory master port
//   operand1, operand2,
//   outputSum                    external adder operands and its combinational sum
module fib_sequence_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BASE_ADDR   = 0,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clockSignal,
  input  logic                   resetSignal,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] termCount,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   readMemorySignal,
  output logic                   writeMemorySignal,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0]  dataToWrite,
  input  logic [DATA_WIDTH-1:0]  dataRead,
  output logic [DATA_WIDTH-1:0]  operand1,
  output logic [DATA_WIDTH-1:0]  operand2,
  input  logic [DATA_WIDTH-1:0]  outputSum
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEED0,
    S_SEED1,
    S_RDA,
    S_RDA_W,
    S_RDB,
    S_RDB_W,
    S_ADD,
    S_WR,
    S_FIN
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_TWO = COUNT_WIDTH'(2);

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] i_q;
  logic [COUNT_WIDTH-1:0] n_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overflow_q;
  logic                   rd_en_q;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  address_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  operand1_q;
  logic [DATA_WIDTH-1:0]  operand2_q;

  logic [COUNT_WIDTH-1:0] i_d;
  logic [COUNT_WIDTH-1:0] n_d;

  // Index of the term after the one being written this cycle.
  assign i_d = i_q + CNT_ONE;
  // N of 0 or 1 still produces the two seed terms, so clamp to 2.
  assign n_d = (termCount < CNT_TWO) ? CNT_TWO : termCount;

  function automatic logic [ADDR_WIDTH-1:0] term_addr(input logic [COUNT_WIDTH-1:0] idx);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
  endfunction

  always_ff @(posedge clockSignal or negedge resetSignal) begin
    if (!resetSignal) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      operand1_q <= '0;
      operand2_q <= '0;
    end else begin
      // Strobes are only held where a state re-asserts them below.
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q        <= n_d;
            i_q        <= CNT_TWO;
            overflow_q <= 1'b0;
`ifdef FIB_SEED_WRITE_EN
            state_q    <= S_SEED0;
            busy_q     <= 1'b1;
            wr_en_q    <= 1'b1;
            address_q  <= term_addr('0);
            wdata_q    <= '0;
`else
            if (n_d == CNT_TWO) begin
              // Seeds are preloaded and nothing is left to compute.
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_RDA;
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b1;
              address_q <= term_addr('0);
            end
`endif
          end
        end

`ifdef FIB_SEED_WRITE_EN
        S_SEED0: begin
          state_q   <= S_SEED1;
          wr_en_q   <= 1'b1;
          address_q <= term_addr(CNT_ONE);
          wdata_q   <= DATA_WIDTH'(1);
        end

        S_SEED1: begin
          if (n_q == CNT_TWO) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_RDA;
            rd_en_q   <= 1'b1;
            address_q <= term_addr(i_q - CNT_TWO);
          end
        end
`endif

        // Each read is held for two cycles so a registered memory also works.
        S_RDA: begin
          state_q <= S_RDA_W;
          rd_en_q <= 1'b1;
        end

        S_RDA_W: begin
          operand1_q <= dataRead;
          state_q    <= S_RDB;
          rd_en_q    <= 1'b1;
          address_q  <= term_addr(i_q - CNT_ONE);
        end

        S_RDB: begin
          state_q <= S_RDB_W;
          rd_en_q <= 1'b1;
        end

        S_RDB_W: begin
          operand2_q <= dataRead;
          state_q    <= S_ADD;
        end

        S_ADD: begin
          // An unsigned sum smaller than an addend means it wrapped.
          if (outputSum < operand1_q) begin
            overflow_q <= 1'b1;
            state_q    <= S_FIN;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            wdata_q   <= outputSum;
            address_q <= term_addr(i_q);
            wr_en_q   <= 1'b1;
            state_q   <= S_WR;
          end
        end

        S_WR: begin
          i_q <= i_d;
          if (i_d == n_q) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_RDA;
            rd_en_q   <= 1'b1;
            address_q <= term_addr(i_d - CNT_TWO);
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign overflow          = overflow_q;
  assign readMemorySignal  = rd_en_q;
  assign writeMemorySignal = wr_en_q;
  assign address           = address_q;
  assign dataToWrite       = wdata_q;
  assign operand1          = operand1_q;
  assign operand2          = operand2_q;

endmodule

// File: tb/tb_fib_sequence_engine.sv
// tb/tb_fib_sequence_engine.sv - scoreboard bench for fib_sequence_engine with memory and adder models
module tb_fib_sequence_engine;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int CW   = 8;
  localparam int BASE = 16;
  localparam int MEMW = 512;

`ifdef FIB_SEED_WRITE_EN
  localparam bit SEEDS = 1'b1;
`else
  localparam bit SEEDS = 1'b0;
`endif
  localparam int N12_DONE = SEEDS ? 63 : 61;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int cycle;
    bit ovf;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] term_count = '0;
  logic          busy, done, overflow, rd_en, wr_en;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata, rdata, op1, op2, sum;

  logic [DW-1:0] mem      [MEMW];
  logic [DW-1:0] mem_snap [MEMW];
  logic [DW-1:0] rd_q;
  bit            reg_mode = 1'b0;
  logic          fill_go = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int wr_seen = 0;
  int last_done_rel = 0;
  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    fib12[12] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89};

  fib_sequence_engine #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .COUNT_WIDTH(CW)
  ) dut (
    .clockSignal      (clk),
    .resetSignal      (rst_n),
    .start            (start),
    .termCount        (term_count),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .readMemorySignal (rd_en),
    .writeMemorySignal(wr_en),
    .address          (address),
    .dataToWrite      (wdata),
    .dataRead         (rdata),
    .operand1         (op1),
    .operand2         (op2),
    .outputSum        (sum)
  );

  always #5 clk = ~clk;

  // External Summation: plain wrapping adder.
  assign sum   = op1 + op2;
  // Memory read is either combinational or one-cycle registered per run.
  assign rdata = reg_mode ? rd_q : mem[address[8:0]];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_q <= mem[address[8:0]];
    if (fill_go) begin
      for (int k = 0; k < MEMW; k++) mem[k] <= $urandom();
      if (!SEEDS) begin
        mem[BASE]   <= '0;
        mem[BASE+1] <= 32'd1;
      end
    end else if (wr_en) begin
      mem[address[8:0]] <= wdata;
    end
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    wr_t   w;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en) begin
          wr_seen++;
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0d, expected no write", address, wdata);
          end else begin
            w = exp_wr.pop_front();
            chk(address == AW'(w.addr), "write_addr", address, w.addr);
            chk(wdata == w.data, "write_data", wdata, w.data);
          end
        end
        if (done) begin
          last_done_rel = cyc - e0 + 1;
          if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done high in cycle %0d, expected low", last_done_rel);
          end else begin
            d = exp_done.pop_front();
            chk(cyc == d.cycle, "done_cycle", last_done_rel, d.cycle - e0 + 1);
            chk(overflow == d.ovf, "done_overflow", overflow, d.ovf);
            chk(busy == 1'b0, "busy_at_done", busy, 0);
          end
        end
      end
    end
  endtask

  // mode 0: plain run, 1: start held then re-pulsed mid-run, 2: reset in cycle 25
  task automatic do_run(input int n, input int mode);
    longint        f[$];
    longint        v;
    int            neff, full, dc, nwr, bad, first_bad;
    bit            ovf;
    wr_t           w;
    done_t         d;
    logic [DW-1:0] expv;

    // Reference: Fibonacci terms in wide arithmetic, stop at the first one past DW bits.
    neff = (n < 2) ? 2 : n;
    ovf  = 1'b0;
    full = 0;
    f.push_back(0);
    f.push_back(1);
    for (int i = 2; i < neff; i++) begin
      v = f[i-1] + f[i-2];
      if (v > 64'd4294967295) begin
        ovf = 1'b1;
        break;
      end
      f.push_back(v);
      full++;
    end
    nwr = 0;
    if (SEEDS) begin
      for (int i = 0; i < 2; i++) begin
        w.addr = BASE + i;
        w.data = f[i][DW-1:0];
        exp_wr.push_back(w);
        nwr++;
      end
    end
    for (int i = 2; i < f.size(); i++) begin
      w.addr = BASE + i;
      w.data = f[i][DW-1:0];
      exp_wr.push_back(w);
      nwr++;
    end
    // Two seed cycles, six per completed term, five for the wrapping term, then done.
    dc = (SEEDS ? 2 : 0) + 6 * full + (ovf ? 5 : 0) + 1;

    @(negedge clk);
    fill_go  = 1'b1;
    reg_mode = bit'($urandom_range(0, 1));
    @(negedge clk);
    fill_go = 1'b0;
    for (int k = 0; k < MEMW; k++) mem_snap[k] = mem[k];
    wr_seen = 0;

    start      = 1'b1;
    term_count = n[CW-1:0];
    @(posedge clk);
    #1;
    e0      = cyc;
    d.cycle = e0 + dc - 1;
    d.ovf   = ovf;
    exp_done.push_back(d);
    chk(busy == (dc > 1), "busy_after_start", busy, dc > 1);
    chk(overflow == 1'b0, "overflow_cleared", overflow, 0);
    term_count = CW'($urandom());

    if (mode == 1) begin
      while (cyc - e0 + 1 < 10) begin @(posedge clk); #1; end
      start = 1'b0;
      while (cyc - e0 + 1 < 20) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end else begin
      start = 1'b0;
    end

    if (mode == 2) begin
      while (cyc - e0 + 1 < 25) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      chk(busy == 1'b0, "reset_busy", busy, 0);
      chk(rd_en == 1'b0, "reset_read_en", rd_en, 0);
      chk(wr_en == 1'b0, "reset_write_en", wr_en, 0);
      chk(address == '0, "reset_address", address, 0);
      exp_wr.delete();
      exp_done.delete();
      repeat (3) @(negedge clk);
      chk(done == 1'b0, "reset_no_done", done, 0);
      rst_n = 1'b1;
      return;
    end

    for (int k = 0; k < 4000 && exp_done.size() != 0; k++) @(posedge clk);
    chk(exp_done.size() == 0, "done_seen", exp_done.size(), 0);
    exp_done.delete();
    repeat (4) @(negedge clk);
    chk(overflow == ovf, "overflow_sticky", overflow, ovf);
    chk(busy == 1'b0, "busy_idle", busy, 0);
    chk(wr_seen == nwr, "write_count", wr_seen, nwr);
    chk(exp_wr.size() == 0, "writes_pending", exp_wr.size(), 0);
    exp_wr.delete();

    bad       = 0;
    first_bad = -1;
    for (int k = 0; k < MEMW; k++) begin
      expv = (k >= BASE && (k - BASE) < f.size()) ? f[k-BASE][DW-1:0] : mem_snap[k];
      if (mem[k] !== expv) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk(bad == 0, "mem_table_bad_words", bad, 0);
    if (bad != 0) $display("  first differing word at address %0d", first_bad);
  endtask

  initial begin
    int bad12;
    fork
      monitor();
    join_none

    #1;
    chk({busy, done, overflow, rd_en, wr_en} == 5'b0, "reset_flags", {busy, done, overflow, rd_en, wr_en}, 0);
    chk(address == '0, "reset_addr", address, 0);
    chk(wdata == '0, "reset_wdata", wdata, 0);
    chk((op1 | op2) == '0, "reset_operands", op1 | op2, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_run(12, 0);
    chk(last_done_rel == N12_DONE, "n12_done_cycle", last_done_rel, N12_DONE);
    bad12 = 0;
    for (int k = 0; k < 12; k++) if (mem[BASE+k] != DW'(fib12[k])) bad12++;
    chk(bad12 == 0, "n12_table", bad12, 0);

    do_run(5, 0);

    do_run(50, 0);
    chk(mem[BASE+47] == 32'd2971215073, "f47_value", mem[BASE+47], 32'd2971215073);
    chk(mem[BASE+48] == mem_snap[BASE+48], "no_write_48", mem[BASE+48], mem_snap[BASE+48]);
    repeat (10) @(negedge clk);
    chk(overflow == 1'b1, "overflow_held", overflow, 1);

    do_run(12, 1);
    bad12 = 0;
    for (int k = 0; k < 12; k++) if (mem[BASE+k] != DW'(fib12[k])) bad12++;
    chk(bad12 == 0, "held_start_table", bad12, 0);

    do_run(12, 2);
    do_run(12, 0);
    chk(last_done_rel == N12_DONE, "post_reset_done_cycle", last_done_rel, N12_DONE);

    do_run(1, 0);
    chk(last_done_rel == (SEEDS ? 3 : 1), "n1_done_cycle", last_done_rel, SEEDS ? 3 : 1);
    do_run(0, 0);
    do_run(2, 0);

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_run(int'($urandom_range(0, 40)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
